data_mem_lsu: RTL and testbench
===============================

// Module: data_mem_lsu
// PURPOSE
//  Load/store unit with an internal data memory. It feeds the memory-read input of the writeback
//  result-select mux. Takes one load/store request from the core at a time.
//  Byte and halfword stores use byte lanes. Loads are sign- or zero-extended.
//  Misaligned and illegal accesses are flagged. Memory latency is configurable, and the core is
//  stalled with a valid/ready handshake until the response arrives.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit memory words; power of 2
//  WAIT_CYCLES  0     extra cycles between request accept and response (0..15)
// PORTS
//  clk           in   1   single clock; all state updates on rising edge
//  rst_n         in   1   synchronous reset, active-low
//  req_valid     in   1   core presents a load/store; held stable until resp_valid
//  req_we        in   1   1 = store, 0 = load
//  req_funct3    in   3   RV32I funct3: LB/LH/LW/LBU/LHU, SB/SH/SW
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data; uses low byte/half/word per funct3
//  req_ready     out  1   1 only in IDLE
//  resp_valid    out  1   one-cycle pulse when the access completes
//  resp_rdata    out  32  extended load data; 0 for stores and errors; held until next response
//  resp_err      out  1   valid with resp_valid: misaligned or illegal funct3
//  stall         out  1   req_valid & ~resp_valid (combinational); freezes core PC/regfile write
// BEHAVIOUR
//  Reset:
//   - state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
//   - Memory array is not reset.
//  FSM IDLE -> BUSY -> DONE -> IDLE:
//   - IDLE: accept on req_valid (req_ready=1). Latch we, funct3, addr, wdata.
//     - If error: go to DONE with err=1. No memory access.
//     - Else if WAIT_CYCLES==0: do the access at the accept edge and go to DONE.
//     - Else: load counter=WAIT_CYCLES and go to BUSY.
//   - BUSY: decrement the counter each cycle. On the edge where the counter is 1, do the access
//     and go to DONE.
//   - DONE: resp_valid=1 for exactly one cycle, then go to IDLE. A new request can be accepted
//     the cycle after DONE.
//  Latency: accept at edge k -> resp_valid high in the cycle after edge k+WAIT_CYCLES+1.
//  Addressing: word index = addr[2 +: log2(DEPTH_WORDS)]. Upper bits are ignored, so addresses
//   alias and wrap. Lane = addr[1:0].
//  Alignment: byte always OK; half needs addr[0]==0; word needs addr[1:0]==0.
//  Illegal funct3: 011, 110, 111 for loads; anything but 000/001/010 for stores.
//  Stores: SB writes lane addr[1:0]; SH writes lanes {addr[1],1}/{addr[1],0}; SW writes all 4 lanes.
//   Unwritten lanes are preserved.
//  Loads:
//   - Select the byte or half from the read word.
//   - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
//  Error responses: rdata=0. Memory is never written on an error.
//  Reset mid-operation: a pending BUSY store is dropped (no write), any DONE pulse is suppressed,
//   and the FSM returns to IDLE.
//  req_valid deasserted while BUSY: the access still completes (core protocol violation,
//   tolerated).
// STRUCTURE
//  Shared package riscv_pkg:
//   - funct3 constants: F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
//   - lsu_state_t enum: IDLE, BUSY, DONE.
//  Sub-module load_extend: combinational (word, lane, funct3) -> extended 32-bit data.
//  Top holds the FSM, counter, byte-lane write and memory array.
// TESTING (WAIT_CYCLES=2 unless noted)
//  1. SW 0xDEADBEEF @0x100 -> resp_valid 3 cycles after accept, err=0.
//     LW @0x100 -> rdata 0xDEADBEEF.
//  2. SB 0x000000AA @0x101 -> LW @0x100 = 0xDEADAAEF.
//     LB @0x101 = 0xFFFFFFAA; LBU @0x101 = 0x000000AA.
//  3. SH 0x00008001 @0x102 -> LH @0x102 = 0xFFFF8001; LHU @0x102 = 0x00008001;
//     LW @0x100 = 0x8001AAEF.
//  4. LW @0x102 -> resp after 1 cycle, err=1, rdata=0.
//     SW @0x203 -> err=1; LW @0x200 returns the prior value.
//     funct3=3'b011 load -> err=1.
//  5. SW 0x0 @0x200, then SW 0x12345678 @0x200 with rst_n=0 during BUSY -> no resp_valid.
//     After reset, LW @0x200 = 0x0.
//  6. WAIT_CYCLES=0 and DEPTH_WORDS=1024: SW 0x5A5A5A5A @0x1100 -> 1-cycle response.
//     LW @0x100 = 0x5A5A5A5A (alias). stall is high exactly while the request is outstanding.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, LSU FSM states and
// the access legality check used when a request is accepted.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // Illegal funct3 or an address that does not suit the access size.
  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [1:0] lane);
    logic illegal;
    logic misal;
    illegal = we ? (f3 > F3_W) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    misal   = (f3[1:0] == 2'b01 && lane[0]) || (f3[1:0] == 2'b10 && lane != 2'b00);
    return illegal | misal;
  endfunction

endpackage

// File: rtl/data_mem_lsu_load_extend.sv
// Picks the addressed byte/half out of a memory word and sign- or zero-extends
// it according to the load funct3.
module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[{i_lane, 3'b000} +: 8];
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_BU:   o_data = {24'h0, w_byte};
      F3_HU:   o_data = {16'h0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit with internal word-organised data memory and byte-lane writes.
// Valid/ready: a request transfers on a rising edge where req_valid && req_ready; the core
// then holds it until the single-cycle resp_valid pulse, and no request is taken during that pulse.
module data_mem_lsu
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall,
  output lsu_state_t  o_dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] r_mem [DEPTH_WORDS];

  lsu_state_t  r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [AW+1:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] r_ld_data;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;

  logic          w_idle;
  logic          w_accept;
  logic          w_err;
  logic          w_access;
  logic          w_we;
  logic [2:0]    w_f3;
  logic [AW+1:0] w_addr;
  logic [31:0]   w_wdata;
  logic [AW-1:0] w_widx;
  logic [1:0]    w_lane;
  logic [3:0]    w_be;
  logic [31:0]   w_wd;
  logic [31:0]   w_ld_data;
  logic          w_unused_addr;

  assign w_idle    = (r_state == IDLE);
  assign req_ready = w_idle && !r_resp_valid;
  assign w_accept  = req_valid && req_ready;
  assign w_err     = access_err(req_we, req_funct3, req_addr[1:0]);

  // Zero-wait accesses use the live request; delayed ones use the latched copy.
  assign w_we    = w_idle ? req_we           : r_we;
  assign w_f3    = w_idle ? req_funct3       : r_f3;
  assign w_addr  = w_idle ? req_addr[AW+1:0] : r_addr;
  assign w_wdata = w_idle ? req_wdata        : r_wdata;
  assign w_widx  = w_addr[AW+1:2];
  assign w_lane  = w_addr[1:0];
  assign w_unused_addr = &{1'b0, req_addr[31:AW+2]};

  assign w_access = rst_n &&
                    ((w_accept && !w_err && WAIT_CYCLES == 0) ||
                     (r_state == BUSY && r_cnt == 4'd1));

  always_comb begin
    w_be = 4'b0000;
    w_wd = w_wdata;
    case (w_f3)
      F3_B: begin
        w_be = 4'b0001 << w_lane;
        w_wd = {4{w_wdata[7:0]}};
      end
      F3_H: begin
        w_be = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{w_wdata[15:0]}};
      end
      F3_W:    w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_access && w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_wd[8*b +: 8];
      end
    end
  end

  load_extend u_load_extend (
    .i_word   (r_mem[w_widx]),
    .i_lane   (w_lane),
    .i_funct3 (w_f3),
    .o_data   (w_ld_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_we         <= 1'b0;
      r_f3         <= 3'd0;
      r_addr       <= '0;
      r_wdata      <= 32'd0;
      r_err        <= 1'b0;
      r_ld_data    <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we    <= req_we;
            r_f3    <= req_funct3;
            r_addr  <= req_addr[AW+1:0];
            r_wdata <= req_wdata;
            r_err   <= w_err;
            if (w_err) begin
              r_state <= DONE;
            end else if (WAIT_CYCLES == 0) begin
              r_ld_data <= w_ld_data;
              r_state   <= DONE;
            end else begin
              r_cnt   <= 4'(WAIT_CYCLES);
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_ld_data <= w_ld_data;
            r_state   <= DONE;
          end
        end
        DONE: begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= r_err;
          r_resp_rdata <= (r_err || r_we) ? 32'd0 : r_ld_data;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign resp_valid  = r_resp_valid;
  assign resp_rdata  = r_resp_rdata;
  assign resp_err    = r_resp_err;
  assign stall       = req_valid && !r_resp_valid;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: one instance with two wait cycles, one with none, checked
// against a byte-addressed reference memory through an expected-response queue.
module tb_data_mem_lsu;
  import riscv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals (index 0: WAIT=2, index 1: WAIT=0) ----------------
  logic        rv [2];
  logic        we;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rdy   [2];
  logic        rsp_v [2];
  logic [31:0] rsp_d [2];
  logic        rsp_e [2];
  logic        stl   [2];
  lsu_state_t  st    [2];

  int wait_of [2] = '{2, 0};

  data_mem_lsu #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_we(we), .req_funct3(f3),
    .req_addr(addr), .req_wdata(wdata), .req_ready(rdy[0]), .resp_valid(rsp_v[0]),
    .resp_rdata(rsp_d[0]), .resp_err(rsp_e[0]), .stall(stl[0]), .o_dbg_state(st[0])
  );

  data_mem_lsu #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_we(we), .req_funct3(f3),
    .req_addr(addr), .req_wdata(wdata), .req_ready(rdy[1]), .resp_valid(rsp_v[1]),
    .resp_rdata(rsp_d[1]), .resp_err(rsp_e[1]), .stall(stl[1]), .o_dbg_state(st[1])
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  logic [41:0] exp_q[$];      // {dut, latency[7:0], err, rdata}
  logic [7:0]  mb [2][4096];  // reference memory, one byte per entry
  logic        pend [2] = '{1'b0, 1'b0};
  int          acc_cyc = 0;
  int          lat_exp = 0;
  logic [31:0] last_rd [2] = '{32'd0, 32'd0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference model: byte-addressed memory, size from funct3, extension by arithmetic.
  task automatic model(input int d, input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] r, output logic e);
    int base;
    int lane;
    int size;
    logic [31:0] val;
    base = int'(a[11:2]) * 4;
    lane = int'(a[1:0]);
    case (f)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    if (w && f > 3'd2) size = 0;
    e = (size == 0) || (lane % size != 0);
    r = 32'd0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < size; i++) mb[d][base + lane + i] = wd[8*i +: 8];
      end else begin
        val = 32'd0;
        for (int i = 0; i < size; i++) val = val | (32'(mb[d][base + lane + i]) << (8*i));
        if ((f == 3'd0 || f == 3'd1) && val[8*size-1]) val = val | ~((32'd1 << (8*size)) - 32'd1);
        r = val;
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic exp_now;
    logic [41:0] ent;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        last_rd[d] = 32'd0;
        pend[d] = 1'b0;
      end else begin
        exp_now = pend[d] && (cyc - acc_cyc == lat_exp);
        if (rsp_v[d] || exp_now) begin
          chk("resp_valid_timing", 32'(rsp_v[d]), 32'(exp_now));
          if (exp_q.size() == 0) begin
            chk("unexpected_resp", 32'(rsp_v[d]), 32'd0);
          end else begin
            ent = exp_q.pop_front();
            if (rsp_v[d]) begin
              chk("resp_dut", 32'(d), 32'(ent[41]));
              chk("resp_rdata", rsp_d[d], ent[31:0]);
              chk("resp_err", 32'(rsp_e[d]), 32'(ent[32]));
            end
            last_rd[d] = ent[31:0];
          end
          pend[d] = 1'b0;
        end else begin
          chk("rdata_hold", rsp_d[d], last_rd[d]);
        end
        chk("stall", 32'(stl[d]), 32'(rv[d] && !exp_now));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input int d, input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] wd);
    logic [31:0] er;
    logic ee;
    int n;
    model(d, w, f, a, wd, er, ee);
    we = w; f3 = f; addr = a; wdata = wd; rv[d] = 1'b1;
    n = 0;
    while (!rdy[d] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rdy[d]) chk("req_ready_timeout", 32'(rdy[d]), 32'd1);
    lat_exp = ee ? 1 : wait_of[d] + 1;
    acc_cyc = cyc + 1;
    exp_q.push_back({d[0], 8'(lat_exp), ee, er});
    pend[d] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_v[d] && n < 40);
    if (!rsp_v[d]) chk("resp_timeout", 32'(rsp_v[d]), 32'd1);
    @(posedge clk); #1;
    rv[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic reset_cycles(input int n);
    rst_n = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rv[0] = 1'b0; rv[1] = 1'b0;
    we = 1'b0; f3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    @(posedge clk); #1;
    reset_cycles(3);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_ready", 32'(rdy[d]), 32'd1);
      chk("reset_resp_valid", 32'(rsp_v[d]), 32'd0);
      chk("reset_rdata", rsp_d[d], 32'd0);
      chk("reset_err", 32'(rsp_e[d]), 32'd0);
      chk("reset_state", 32'(st[d]), 32'(IDLE));
    end
    @(posedge clk); #1;

    // word, byte and half stores with loads of every width (two-wait instance)
    do_req(0, 1'b1, F3_W,  32'h100, 32'hDEADBEEF);
    do_req(0, 1'b0, F3_W,  32'h100, 32'h0);
    do_req(0, 1'b1, F3_B,  32'h101, 32'h000000AA);
    do_req(0, 1'b0, F3_W,  32'h100, 32'h0);
    do_req(0, 1'b0, F3_B,  32'h101, 32'h0);
    do_req(0, 1'b0, F3_BU, 32'h101, 32'h0);
    do_req(0, 1'b1, F3_H,  32'h102, 32'h00008001);
    do_req(0, 1'b0, F3_H,  32'h102, 32'h0);
    do_req(0, 1'b0, F3_HU, 32'h102, 32'h0);
    do_req(0, 1'b0, F3_W,  32'h100, 32'h0);
    // errors: misaligned load/store, illegal load funct3
    do_req(0, 1'b0, F3_W,  32'h102, 32'h0);
    do_req(0, 1'b1, F3_W,  32'h200, 32'h0);
    do_req(0, 1'b1, F3_W,  32'h203, 32'hFFFFFFFF);
    do_req(0, 1'b0, F3_W,  32'h200, 32'h0);
    do_req(0, 1'b0, 3'b011, 32'h200, 32'h0);

    // reset lands on the edge the delayed store would have written
    we = 1'b1; f3 = F3_W; addr = 32'h200; wdata = 32'h12345678; rv[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; rv[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_state", 32'(st[0]), 32'(IDLE));
    chk("post_reset_ready", 32'(rdy[0]), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    do_req(0, 1'b0, F3_W, 32'h200, 32'h0);

    // zero-wait instance, including an aliased address
    do_req(1, 1'b1, F3_W, 32'h1100, 32'h5A5A5A5A);
    do_req(1, 1'b0, F3_W, 32'h100, 32'h0);
    do_req(1, 1'b0, F3_H, 32'h102, 32'h0);

    // randomized traffic over a pre-written low region, upper address bits random
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++)
        do_req(d, 1'b1, F3_W, 32'(i * 4), $urandom);
    for (int i = 0; i < 80; i++)
      do_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)), $urandom);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
